// File: rtl/cd_rx_des.sv
// Byte deserializer for an asynchronous, idle-high bus. Each byte is checked
// against CRC-16/MODBUS, and frames are delimited by idle periods on the bus.
module cd_rx_des (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [15:0] period_ls,
    input  logic [15:0] period_hs,
    input  logic [7:0]  idle_wait_len,
    input  logic        force_wait_idle,
    output logic        bus_idle,
    output logic [7:0]  rx_data,
    output logic [15:0] crc_data,
    output logic        data_clk
);

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data_in);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data_in};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    logic        sync1_r, sync2_r, rxs_d_r;
    state_t      state_r, state_s;
    logic [15:0] bit_cnt_r, bit_cnt_s;
    logic [7:0]  idle_cnt_r, idle_cnt_s;
    logic [2:0]  bit_idx_r, bit_idx_s;
    logic [7:0]  shift_r, shift_s;
    logic        use_hs_r, use_hs_s;
    logic        in_frame_r, in_frame_s;
    logic        bus_idle_r, bus_idle_s;
    logic [7:0]  rx_data_r, rx_data_s;
    logic [15:0] crc_r, crc_s;
    logic        data_clk_r, data_clk_s;

    logic        rxs_s, fall_s, bit_done_s;
    logic [15:0] period_sel_s, cnt_dec_s;
    logic [7:0]  idle_thr_s;

    assign rxs_s        = sync2_r;
    assign fall_s       = rxs_d_r & ~sync2_r;
    assign bit_done_s   = (bit_cnt_r == 16'd0);
    assign cnt_dec_s    = bit_cnt_r - 16'd1;
    assign period_sel_s = use_hs_r ? period_hs : period_ls;
    assign idle_thr_s   = (idle_wait_len == 8'd0) ? 8'd1 : idle_wait_len;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            rxs_d_r <= 1'b1;
        end else begin
            sync1_r <= rx;
            sync2_r <= sync1_r;
            rxs_d_r <= sync2_r;
        end
    end

    // Next-state and output computation; a byte start in WAIT is only honoured while in_frame_r is set.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        idle_cnt_s = idle_cnt_r;
        bit_idx_s  = bit_idx_r;
        shift_s    = shift_r;
        use_hs_s   = use_hs_r;
        in_frame_s = in_frame_r;
        bus_idle_s = bus_idle_r;
        rx_data_s  = rx_data_r;
        crc_s      = crc_r;
        data_clk_s = 1'b0;
        if (force_wait_idle) begin
            state_s    = ST_WAIT;
            idle_cnt_s = 8'd0;
            bus_idle_s = 1'b0;
            in_frame_s = 1'b0;
            bit_cnt_s  = period_ls;
        end else begin
            case (state_r)
                ST_WAIT: begin
                    if (fall_s && in_frame_r) begin
                        state_s    = ST_START;
                        bit_cnt_s  = period_sel_s >> 1;
                        idle_cnt_s = 8'd0;
                        bus_idle_s = 1'b0;
                    end else if (!rxs_s) begin
                        idle_cnt_s = 8'd0;
                        bit_cnt_s  = period_ls;
                    end else if (bit_done_s) begin
                        bit_cnt_s = period_ls;
                        if (({1'b0, idle_cnt_r} + 9'd1) >= {1'b0, idle_thr_s}) begin
                            state_s    = ST_IDLE;
                            idle_cnt_s = 8'd0;
                            bus_idle_s = 1'b1;
                            crc_s      = 16'hFFFF;
                            use_hs_s   = 1'b0;
                            in_frame_s = 1'b1;
                        end else begin
                            idle_cnt_s = idle_cnt_r + 8'd1;
                        end
                    end else begin
                        bit_cnt_s = cnt_dec_s;
                    end
                end
                ST_IDLE: begin
                    if (fall_s) begin
                        state_s    = ST_START;
                        bit_cnt_s  = period_sel_s >> 1;
                        bus_idle_s = 1'b0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (bit_done_s) begin
                        if (rxs_s) begin
                            state_s    = ST_WAIT;
                            idle_cnt_s = 8'd0;
                            in_frame_s = 1'b0;
                            bit_cnt_s  = period_ls;
                        end else begin
                            state_s   = ST_DATA;
                            bit_cnt_s = period_sel_s;
                            bit_idx_s = 3'd0;
                        end
                    end else begin
                        bit_cnt_s = cnt_dec_s;
                    end
                end
                ST_DATA: begin
                    if (bit_done_s) begin
                        shift_s   = {rxs_s, shift_r[7:1]};
                        bit_cnt_s = period_sel_s;
                        bit_idx_s = bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_s = ST_STOP;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else begin
                        bit_cnt_s = cnt_dec_s;
                    end
                end
                ST_STOP: begin
                    if (bit_done_s) begin
                        state_s    = ST_WAIT;
                        bit_cnt_s  = period_ls;
                        idle_cnt_s = 8'd0;
                        if (rxs_s) begin
                            rx_data_s  = shift_r;
                            crc_s      = crc16_byte(crc_r, shift_r);
                            data_clk_s = 1'b1;
                            use_hs_s   = 1'b1;
                        end else begin
                            in_frame_s = 1'b0;
                        end
                    end else begin
                        bit_cnt_s = cnt_dec_s;
                    end
                end
                default: begin
                    state_s    = ST_WAIT;
                    idle_cnt_s = 8'd0;
                    in_frame_s = 1'b0;
                    bus_idle_s = 1'b0;
                    bit_cnt_s  = period_ls;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_WAIT;
            bit_cnt_r  <= period_ls;
            idle_cnt_r <= 8'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            use_hs_r   <= 1'b0;
            in_frame_r <= 1'b0;
            bus_idle_r <= 1'b0;
            rx_data_r  <= 8'd0;
            crc_r      <= 16'hFFFF;
            data_clk_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            idle_cnt_r <= idle_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            use_hs_r   <= use_hs_s;
            in_frame_r <= in_frame_s;
            bus_idle_r <= bus_idle_s;
            rx_data_r  <= rx_data_s;
            crc_r      <= crc_s;
            data_clk_r <= data_clk_s;
        end
    end

    assign bus_idle = bus_idle_r;
    assign rx_data  = rx_data_r;
    assign crc_data = crc_r;
    assign data_clk = data_clk_r;

endmodule

// File: doc/cd_rx_des.md
CD_RX_DES -- requirements
Module: cd_rx_des

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx  in  1  asynchronous bus receive line, idle high
- period_ls  in  16  arbitration bit period minus 1, in clk cycles
- period_hs  in  16  data-phase bit period minus 1, in clk cycles
- idle_wait_len  in  8  idle threshold in arbitration bit times; 0 is treated as 1
- force_wait_idle  in  1  one-cycle request to discard the current activity and wait for the next idle
- bus_idle  out  1  bus idle indication
- rx_data  out  8  last received byte
- crc_data  out  16  running CRC, including rx_data
- data_clk  out  1  one-cycle strobe marking a new rx_data/crc_data

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs), with 2 cycles of input latency.
REQ-004 The FSM SHALL have states WAIT, IDLE, START, DATA and STOP.
REQ-005 WAIT: each consecutive arbitration bit time (period_ls+1 cycles) with rxs high SHALL advance idle_cnt; any rxs low SHALL clear idle_cnt.
REQ-006 WAIT: when idle_cnt reaches max(idle_wait_len,1), the next cycle SHALL set bus_idle=1, set crc_data=16'hFFFF, select period_ls, and enter IDLE.
REQ-007 WAIT or IDLE: an rxs falling edge SHALL enter START and load the bit counter with half the selected period (period>>1).
- bus_idle SHALL drop to 0 in the same cycle START is entered.
REQ-008 START: if the half-period expires with rxs high (false start), the FSM SHALL return to WAIT with idle_cnt=0.
- Otherwise it SHALL enter DATA and load the full period.
REQ-009 DATA: the FSM SHALL sample 8 bits, LSB first, one per period+1 cycles, at mid-bit.
- A 3-bit counter SHALL select the shift position.
- After bit 7 the FSM SHALL enter STOP.
REQ-010 STOP, at mid-bit: if rxs=1, the next cycle SHALL update rx_data, update crc_data with that byte, pulse data_clk for exactly 1 cycle, and enter WAIT.
REQ-011 STOP with rxs=0 (framing error) SHALL emit no data_clk and enter WAIT with idle_cnt=0.
- The frame continues only after a new idle.
REQ-012 The first byte after IDLE SHALL use period_ls; subsequent bytes SHALL use period_hs until the next IDLE.
REQ-013 The CRC SHALL be CRC-16/MODBUS: reflected poly 0xA001, init 0xFFFF, computed one byte per cycle, no final XOR.
- Over a frame whose last two bytes are the little-endian CRC, crc_data SHALL read 0x0000 at the final data_clk.
REQ-014 rx_data and crc_data SHALL hold their values between data_clk strobes.
- crc_data changes only on data_clk or IDLE entry.
REQ-015 force_wait_idle SHALL, in any state, force WAIT with idle_cnt=0 and bus_idle=0 on the next cycle, and suppress any data_clk pending in that cycle.
REQ-016 force_wait_idle and a STOP-complete event in the same cycle SHALL resolve in favour of force_wait_idle.
REQ-017 Bit counters SHALL be 16-bit, count down to 0, and reload; period values SHALL be sampled at each reload.
- Changing a period mid-bit SHALL take effect at the next bit.
REQ-018 A period_hs or period_ls value below 2 is out of range and its behaviour is unspecified.

Reset
REQ-019 During reset the outputs SHALL be: bus_idle=0, rx_data=0, crc_data=16'hFFFF, data_clk=0.
- State SHALL be WAIT with idle_cnt=0, and the synchronizer flops SHALL be set to 1.
REQ-020 Reset asserted mid-byte SHALL discard the partial byte with no data_clk.
- bus_idle SHALL rise only after a full idle_wait_len period following release.

Verification
REQ-021 rx held high, period_ls=7, idle_wait_len=10 -> bus_idle rises exactly 80 cycles (+2 synchronizer) after reset release.
REQ-022 After idle, send ASCII "123456789" then 0x37, 0x4B (period_ls=7, period_hs=3) -> 11 data_clk pulses, crc_data=0x4B37 at the 9th and 0x0000 at the 11th, with the first byte at 8 cycles/bit and the rest at 4 cycles/bit.
REQ-023 A 3-cycle low glitch on rx with period_ls=15 -> false start, no data_clk, bus_idle=0, and idle re-qualified afterwards.
REQ-024 Byte 0x55 with a low stop bit -> no data_clk, FSM in WAIT, and the next byte accepted only after idle_wait_len idle bit times.
REQ-025 force_wait_idle pulsed during bit 4 of a byte -> no data_clk for that byte, bus_idle=0 until idle re-qualified, and the next frame starts with crc_data=0xFFFF and period_ls.
REQ-026 Reset asserted during DATA -> outputs equal the REQ-019 values and no data_clk occurs.
